// File: rtl/pending_encoder_8to3.sv
// pending_encoder_8to3
// Collapses a set of request lines into a single encoded index. Requests are
// captured in a sticky pending register. The selected index is presented on a
// registered valid/ready output stage. A pending bit is released when its
// index is accepted, unless the same bit is re-requested in that cycle.
// Selection is either fixed priority (lowest index wins) or round-robin,
// starting just after the most recently accepted index.

module pending_encoder_8to3 #(
    parameter int N_REQ       = 8,
    parameter int IDX_W       = 3,
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_in,
    input  logic             clear_all,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [N_REQ-1:0] pending
);

    // ------------------------------------------------------------------
    // Selection helpers
    // ------------------------------------------------------------------

    // Lowest set bit of vec. Scanning downward lets the last hit, which is
    // the lowest index, win.
    function automatic logic [IDX_W-1:0] sel_fixed(input logic [N_REQ-1:0] vec);
        logic [IDX_W-1:0] sel;
        sel = {IDX_W{1'b0}};
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                sel = IDX_W'(i);
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    // First set bit of vec, searching upward from ptr and wrapping at the top.
    // The search offset is scanned downward, so the smallest offset wins.
    function automatic logic [IDX_W-1:0] sel_rr(input logic [N_REQ-1:0] vec,
                                                input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] sel;
        int               j;
        sel = {IDX_W{1'b0}};
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N_REQ;
            if (vec[j]) begin
                sel = IDX_W'(j);
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [N_REQ-1:0] pending_r;
    logic             out_valid_r;
    logic [IDX_W-1:0] out_idx_r;
    logic [IDX_W-1:0] rr_ptr_r;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic             hs_s;
    logic [N_REQ-1:0] ack_mask_s;
    logic [N_REQ-1:0] cand_s;
    logic             any_cand_s;
    logic [IDX_W-1:0] sel_s;
    logic             load_s;
    logic [N_REQ-1:0] pending_nxt_s;

    // Handshake, acknowledge mask and the candidate set. The candidate set
    // excludes the index being accepted now and never includes same-cycle
    // requests.
    always_comb begin
        hs_s       = out_valid_r & out_ready;
        ack_mask_s = {N_REQ{1'b0}};
        if (hs_s) begin
            ack_mask_s = {{(N_REQ-1){1'b0}}, 1'b1} << out_idx_r;
        end else begin
            ack_mask_s = {N_REQ{1'b0}};
        end
        cand_s     = pending_r & ~ack_mask_s;
        any_cand_s = |cand_s;
    end

    // Winner among the candidates, using the configured arbitration.
    always_comb begin
        sel_s = {IDX_W{1'b0}};
        if (ROUND_ROBIN) begin
            sel_s = sel_rr(cand_s, rr_ptr_r);
        end else begin
            sel_s = sel_fixed(cand_s);
        end
    end

    // The output stage may reload when it is empty or its index is being
    // accepted. A flush takes precedence.
    always_comb begin
        load_s = (~out_valid_r | hs_s) & ~clear_all;
    end

    // Next pending value. A flush drops everything, including same-cycle
    // requests. Otherwise a new request wins over the acknowledge of the
    // same bit.
    always_comb begin
        pending_nxt_s = pending_r;
        if (clear_all) begin
            pending_nxt_s = {N_REQ{1'b0}};
        end else begin
            pending_nxt_s = (pending_r & ~ack_mask_s) | req_in;
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // Sticky pending register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= {N_REQ{1'b0}};
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    // Output valid: cleared by a flush, reloaded when the stage is free,
    // and otherwise held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
        end else if (clear_all) begin
            out_valid_r <= 1'b0;
        end else if (load_s) begin
            out_valid_r <= any_cand_s;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Output index: changes only on a reload that has a candidate. It keeps
    // its last value when nothing is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_idx_r <= {IDX_W{1'b0}};
        end else if (load_s && any_cand_s) begin
            out_idx_r <= sel_s;
        end else begin
            out_idx_r <= out_idx_r;
        end
    end

    // Round-robin pointer: moves to just past each accepted index. A
    // handshake during a flush still counts. It wraps naturally at N_REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= {IDX_W{1'b0}};
        end else if (hs_s) begin
            rr_ptr_r <= out_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all driven directly from registers)
    // ------------------------------------------------------------------
    assign out_valid = out_valid_r;
    assign out_idx   = out_idx_r;
    assign pending   = pending_r;

endmodule

// File: tb/tb_pending_encoder_8to3.sv
// tb_pending_encoder_8to3
// Drives one fixed-priority instance and one round-robin instance with the
// same stimulus: first directed scenarios, then a randomized run. Both are
// compared every cycle against a request-level reference model.

module tb_pending_encoder_8to3;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_in;
    logic       clear_all;
    logic       out_ready;

    logic       fx_valid;
    logic [2:0] fx_idx;
    logic [7:0] fx_pend;
    logic       rr_valid;
    logic [2:0] rr_idx;
    logic [7:0] rr_pend;

    int n_cmp;
    int n_err;

    // Reference model state. Index 0 is fixed priority, index 1 is round-robin.
    bit pend_m [2][8];
    bit valid_m [2];
    int idx_m [2];
    int rr_m [2];

    pending_encoder_8to3 #(.N_REQ(8), .IDX_W(3), .ROUND_ROBIN(1'b0)) u_fx (
        .clk(clk), .rst_n(rst_n), .req_in(req_in), .clear_all(clear_all),
        .out_ready(out_ready), .out_valid(fx_valid), .out_idx(fx_idx), .pending(fx_pend)
    );

    pending_encoder_8to3 #(.N_REQ(8), .IDX_W(3), .ROUND_ROBIN(1'b1)) u_rr (
        .clk(clk), .rst_n(rst_n), .req_in(req_in), .clear_all(clear_all),
        .out_ready(out_ready), .out_valid(rr_valid), .out_idx(rr_idx), .pending(rr_pend)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, obs, obs, exp, exp, $time);
        end
    endtask

    function automatic int pend_word(input int u);
        int w;
        w = 0;
        for (int i = 0; i < 8; i++) if (pend_m[u][i]) w += (1 << i);
        return w;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 8; i++) pend_m[u][i] = 1'b0;
            valid_m[u] = 1'b0;
            idx_m[u]   = 0;
            rr_m[u]    = 0;
        end
    endtask

    // One clock of the reference model, from the inputs applied this cycle.
    task automatic model_clock();
        for (int u = 0; u < 2; u++) begin
            bit hs;
            int acked;
            bit cand [8];
            int sel;
            hs    = valid_m[u] && out_ready;
            acked = hs ? idx_m[u] : -1;
            for (int i = 0; i < 8; i++) cand[i] = pend_m[u][i] && (i != acked);
            sel = -1;
            for (int k = 0; k < 8; k++) begin
                int j;
                j = (u == 1) ? (rr_m[u] + k) % 8 : k;
                if (sel < 0 && cand[j]) sel = j;
            end
            if (hs) rr_m[u] = (idx_m[u] + 1) % 8;
            if (clear_all) begin
                valid_m[u] = 1'b0;
            end else if (!valid_m[u] || hs) begin
                valid_m[u] = (sel >= 0);
                if (sel >= 0) idx_m[u] = sel;
            end
            for (int i = 0; i < 8; i++)
                pend_m[u][i] = clear_all ? 1'b0 : (cand[i] || req_in[i]);
        end
    endtask

    task automatic compare_all();
        check("fx_valid", int'(fx_valid), int'(valid_m[0]));
        check("fx_idx", int'(fx_idx), idx_m[0]);
        check("fx_pending", int'(fx_pend), pend_word(0));
        check("rr_valid", int'(rr_valid), int'(valid_m[1]));
        check("rr_idx", int'(rr_idx), idx_m[1]);
        check("rr_pending", int'(rr_pend), pend_word(1));
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        compare_all();
    endtask

    // Asynchronous reset asserted mid-cycle. Outputs must clear immediately.
    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_fx_valid", int'(fx_valid), 0);
        check("rst_fx_idx", int'(fx_idx), 0);
        check("rst_fx_pending", int'(fx_pend), 0);
        check("rst_rr_valid", int'(rr_valid), 0);
        check("rst_rr_pending", int'(rr_pend), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle_inputs();
        req_in    = 8'h00;
        clear_all = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b1;
        req_in    = 8'h00;
        clear_all = 1'b0;
        out_ready = 1'b1;
        #2;
        async_reset();

        // Scenario 1: fixed priority, 8'hA0 for one cycle -> 5 then 7.
        out_ready = 1'b1;
        req_in    = 8'hA0;
        step();
        idle_inputs();
        step();
        check("t1_first_idx", int'(fx_idx), 5);
        check("t1_first_valid", int'(fx_valid), 1);
        step();
        check("t1_second_idx", int'(fx_idx), 7);
        step();
        check("t1_done_valid", int'(fx_valid), 0);
        check("t1_done_pending", int'(fx_pend), 0);

        // Scenario 2: backpressure holds the presented index.
        out_ready = 1'b0;
        req_in    = 8'h40;
        step();
        idle_inputs();
        step();
        step();
        req_in = 8'h02;
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_hold_idx", int'(fx_idx), 6);
        end
        out_ready = 1'b1;
        step();
        check("t2_next_idx", int'(fx_idx), 1);
        step();
        step();

        // Scenario 3: a re-request in the acceptance cycle keeps the bit pending.
        out_ready = 1'b0;
        req_in    = 8'h08;
        step();
        idle_inputs();
        step();
        step();
        out_ready = 1'b1;
        req_in    = 8'h08;
        step();
        check("t3_sticky_bit", int'(fx_pend[3]), 1);
        idle_inputs();
        for (int i = 0; i < 4; i++) step();

        // Scenario 4: round-robin over held 8'hFF from a fresh pointer.
        async_reset();
        out_ready = 1'b1;
        req_in    = 8'hFF;
        step();
        for (int k = 0; k < 10; k++) begin
            step();
            check("t4_rr_seq", int'(rr_idx), k % 8);
            check("t4_rr_valid", int'(rr_valid), 1);
        end
        idle_inputs();
        for (int i = 0; i < 10; i++) step();

        // Scenario 5: a flush drops the pending set, the output and a same-cycle request.
        out_ready = 1'b0;
        req_in    = 8'h0F;
        step();
        idle_inputs();
        step();
        check("t5_pre_pending", int'(fx_pend), 8'h0F);
        check("t5_pre_valid", int'(fx_valid), 1);
        clear_all = 1'b1;
        req_in    = 8'h80;
        step();
        check("t5_flush_pending", int'(fx_pend), 0);
        check("t5_flush_valid", int'(fx_valid), 0);
        idle_inputs();
        out_ready = 1'b1;
        step();
        check("t5_bit7_dropped", int'(fx_valid), 0);

        // Scenario 6: asynchronous reset mid-stream, then quiet.
        out_ready = 1'b0;
        req_in    = 8'h3C;
        step();
        idle_inputs();
        step();
        step();
        check("t6_pre_pending", int'(fx_pend), 8'h3C);
        async_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t6_quiet_valid", int'(fx_valid), 0);
        end

        // Randomized run.
        for (int c = 0; c < 3000; c++) begin
            req_in    = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            out_ready = ($urandom_range(0, 3) != 0);
            clear_all = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 400) == 0) begin
                async_reset();
            end else begin
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
